program_loader: RTL and testbench

- Writer side of the MIPS instruction memory write port (Wr / Addr / In_Data).
- Receives a byte stream from the UART receiver, assembles each 4 bytes into one 32-bit instruction (MSB first), and writes it into instruction memory at sequential word addresses starting at 0.
- Loading ends when a HALT word (opcode 111111) is written or when memory is full.
- Sits between the UART RX / debug unit and the INSTRUCTION_MEM write port.

---
 rtl/program_loader_pkg.sv | 23 ++
 rtl/program_loader_byte_assembler.sv | 51 +++++
 rtl/program_loader.sv | 142 ++++++++++++++
 tb/tb_program_loader.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
//   state_t        : loader FSM encoding (IDLE, RECV, WRITE, DONE)
//   HALT_OPCODE    : opcode that terminates a load (the HALT word is still written)
//   BYTES_PER_WORD : bytes per instruction at the default 32-bit width
//   bytes_per_word : the same figure for an arbitrary instruction width
package program_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [5:0] HALT_OPCODE    = 6'b111111;
  localparam int         LEN_DATA_DEF   = 32;
  localparam int         BYTES_PER_WORD = LEN_DATA_DEF / 8;

  function automatic int bytes_per_word(input int len_data);
    return len_data / 8;
  endfunction

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Packs a UART byte stream into len_data-bit words, MSB first.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   clear          : drop any partial word (new load armed)
//   flush          : drop any partial word (inter-byte timeout)
//   byte_en        : accept rx_data this cycle
//   rx_data        : incoming byte
//   word           : shift register with the current byte appended
//   word_valid     : byte_en on the last byte of a word; word is complete
//   partial        : at least one byte of a word is held
module program_loader_byte_assembler
  import program_loader_pkg::*;
#(
  parameter int len_data = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                flush,
  input  logic                byte_en,
  input  logic [7:0]          rx_data,
  output logic [len_data-1:0] word,
  output logic                word_valid,
  output logic                partial
);

  localparam int BPW = bytes_per_word(len_data);
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [len_data-1:0] shreg;
  logic [CW-1:0]       cnt;
  logic                last_byte;

  assign last_byte  = (cnt == CW'(BPW - 1));
  // Combinational view so the caller can register the full word on the
  // same edge that takes in the final byte.
  assign word       = {shreg[len_data-9:0], rx_data};
  assign word_valid = byte_en && last_byte;
  assign partial    = (cnt != '0);

  always_ff @(posedge clk) begin
    if (reset || clear || flush) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (byte_en) begin
      shreg <= word;
      cnt   <= last_byte ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Writer side of the instruction-memory write port. Assembles bytes from the
// UART receiver into instructions and writes them to sequential word
// addresses from 0 until a HALT word has been written or memory is full.
// Optional macro LOADER_TIMEOUT_EN: discard a partial word after
// timeout_cycles idle clocks and pulse timeout_err.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   start                : one-cycle pulse, arms a load from address 0
//   rx_data, rx_done     : received byte and its valid strobe
//   mem_wr/addr/data     : instruction memory write port
//   busy                 : armed or loading
//   load_done            : level, load finished (until next start/reset)
//   overflow             : level, memory filled without a HALT
//   word_count           : words written in the current or last load
//   timeout_err          : (LOADER_TIMEOUT_EN only) partial word dropped
module program_loader
  import program_loader_pkg::*;
#(
  parameter int len_addr       = 32,
  parameter int len_data       = 32,
  parameter int ram_depth      = 2048,
  parameter int timeout_cycles = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          rx_data,
  input  logic                rx_done,
  output logic                mem_wr,
  output logic [len_addr-1:0] mem_addr,
  output logic [len_data-1:0] mem_data,
  output logic                busy,
  output logic                load_done,
  output logic                overflow,
  output logic [len_addr-1:0] word_count
`ifdef LOADER_TIMEOUT_EN
  , output logic              timeout_err
`endif
);

  state_t              state, nxt;
  logic                byte_en, clear, flush;
  logic [len_data-1:0] word;
  logic                word_valid, partial;
  logic                is_halt, at_last;

  // A byte landing in the WRITE cycle is the first byte of the next word.
  assign byte_en = rx_done && (state == RECV || state == WRITE);
  assign clear   = (state == IDLE) && start;
  assign is_halt = (mem_data[len_data-1 -: 6] == HALT_OPCODE);
  assign at_last = (mem_addr == len_addr'(ram_depth - 1));

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] idle_cnt;
  logic        counting;

  assign counting = (state == RECV) && partial && !rx_done;
  assign flush    = counting && (idle_cnt == 32'(timeout_cycles - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= flush;
      idle_cnt    <= (!counting || flush) ? '0 : idle_cnt + 1'b1;
    end
  end
`else
  assign flush = 1'b0;
`endif

  program_loader_byte_assembler #(.len_data(len_data)) u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .flush      (flush),
    .byte_en    (byte_en),
    .rx_data    (rx_data),
    .word       (word),
    .word_valid (word_valid),
    .partial    (partial)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Next state
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = RECV;
      RECV:    if (word_valid) nxt = WRITE;
      WRITE:   nxt = (is_halt || at_last) ? DONE : RECV;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    mem_wr = (state == WRITE);
    busy   = (state == RECV) || (state == WRITE);
  end

  // Address, data and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr   <= '0;
      mem_data   <= '0;
      word_count <= '0;
      load_done  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mem_addr   <= '0;
          word_count <= '0;
          load_done  <= 1'b0;
          overflow   <= 1'b0;
        end
        RECV: if (word_valid) mem_data <= word;
        WRITE: begin
          word_count <= word_count + 1'b1;
          if (is_halt) begin
            load_done <= 1'b1;
          end else if (at_last) begin
            load_done <= 1'b1;
            overflow  <= 1'b1;
          end else begin
            mem_addr <= mem_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        reset, start, rx_done;
  logic [7:0]  rx_data;
  logic        mem_wr, busy, load_done, overflow;
  logic [31:0] mem_addr, mem_data, word_count;
`ifdef LOADER_TIMEOUT_EN
  logic        timeout_err;
`endif

  always #5 clk = ~clk;

  program_loader #(
    .len_addr(32), .len_data(32), .ram_depth(RD), .timeout_cycles(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .busy       (busy),
    .load_done  (load_done),
    .overflow   (overflow),
    .word_count (word_count)
`ifdef LOADER_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  logic prev_wr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write monitor: counts writes, write strobe is a single cycle, address in range.
  always @(negedge clk) begin
    if (mem_wr === 1'b1) begin
      wr_cnt++;
      chk("wr_single_cycle", {31'd0, prev_wr}, 32'd0);
      chk("wr_addr_range", {31'd0, mem_addr <= RD - 1}, 32'd1);
    end
    prev_wr = (mem_wr === 1'b1);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_done = 1'b1;
    step();
    rx_done = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[31-8*k -: 8]);
      if (k < 3) repeat (gap) step();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  typedef struct {
    logic        first;     // pulse start before this word
    logic [31:0] word;
    int          gap;       // idle cycles between bytes and after the word
    logic [31:0] exp_addr;
    logic        last;      // load ends after this word
    logic        exp_ovf;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int base;
    int seen;

    // Program A: spaced bytes, HALT terminates
    vecs[0] = '{1'b1, 32'h20080005, 1, 32'd0, 1'b0, 1'b0, 32'd0};
    vecs[1] = '{1'b0, 32'hFC000000, 1, 32'd1, 1'b1, 1'b0, 32'd2};
    // Program B: back-to-back bytes, one byte lands in every WRITE cycle
    vecs[2] = '{1'b1, 32'h01020304, 0, 32'd0, 1'b0, 1'b0, 32'd0};
    vecs[3] = '{1'b0, 32'hA5B6C7D8, 0, 32'd1, 1'b0, 1'b0, 32'd0};
    vecs[4] = '{1'b0, 32'hFFFFFFFF, 0, 32'd2, 1'b1, 1'b0, 32'd3};
    // Program C: fills the 4-entry memory with no HALT
    vecs[5] = '{1'b1, 32'h00000001, 0, 32'd0, 1'b0, 1'b0, 32'd0};
    vecs[6] = '{1'b0, 32'h00000002, 0, 32'd1, 1'b0, 1'b0, 32'd0};
    vecs[7] = '{1'b0, 32'h00000003, 0, 32'd2, 1'b0, 1'b0, 32'd0};
    vecs[8] = '{1'b0, 32'h00000004, 0, 32'd3, 1'b1, 1'b1, 32'd4};

    reset = 1'b1; start = 1'b0; rx_done = 1'b0; rx_data = 8'h00;
    step(); step();
    reset = 1'b0;
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_data", mem_data, 32'd0);
    chk("rst_status", {28'd0, busy, load_done, overflow, 1'b0}, 32'd0);
    chk("rst_word_count", word_count, 32'd0);

    // Bytes before start are ignored
    base = wr_cnt;
    send_word(32'h12345678, 0);
    step();
    chk("idle_no_write", wr_cnt - base, 32'd0);
    chk("idle_not_busy", {31'd0, busy}, 32'd0);

    base = 0;
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].first) begin
        pulse_start();
        chk($sformatf("v%0d_busy_armed", i), {31'd0, busy}, 32'd1);
        chk($sformatf("v%0d_done_cleared", i), {31'd0, load_done}, 32'd0);
        base = wr_cnt;
      end
      send_word(vecs[i].word, vecs[i].gap);
      chk($sformatf("v%0d_mem_wr", i), {31'd0, mem_wr}, 32'd1);
      chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_mem_data", i), mem_data, vecs[i].word);
      if (vecs[i].last) begin
        step();
        chk($sformatf("v%0d_load_done", i), {31'd0, load_done}, 32'd1);
        chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd0);
        chk($sformatf("v%0d_overflow", i), {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
        chk($sformatf("v%0d_word_count", i), word_count, vecs[i].exp_cnt);
        chk($sformatf("v%0d_writes", i), wr_cnt - base, vecs[i].exp_cnt);
        step();
        chk($sformatf("v%0d_done_held", i), {31'd0, load_done}, 32'd1);
      end else begin
        repeat (vecs[i].gap) step();
      end
    end

    // After overflow: further bytes produce no write to address 4
    base = wr_cnt;
    send_word(32'h00000005, 0);
    step();
    chk("ovf_no_extra_write", wr_cnt - base, 32'd0);
    chk("ovf_addr_held", mem_addr, 32'd3);

    // Reset mid-word: stale bytes must not leak into the next load
    pulse_start();
    send_byte(8'hAA); send_byte(8'hBB);
    reset = 1'b1; step(); reset = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_load_done", {31'd0, load_done}, 32'd0);
    base = wr_cnt;
    pulse_start();
    send_word(32'h11223344, 0);
    chk("midrst_mem_wr", {31'd0, mem_wr}, 32'd1);
    chk("midrst_addr", mem_addr, 32'd0);
    chk("midrst_data", mem_data, 32'h11223344);
    step();
    chk("midrst_one_write", wr_cnt - base, 32'd1);

    // start while loading is ignored
    pulse_start();
    chk("busy_start_addr", mem_addr, 32'd1);
    send_word(32'h0A0B0C0D, 1);
    chk("busy_start_wr", {31'd0, mem_wr}, 32'd1);
    chk("busy_start_wr_addr", mem_addr, 32'd1);
    chk("busy_start_wr_data", mem_data, 32'h0A0B0C0D);
    reset = 1'b1; step(); reset = 1'b0;

`ifdef LOADER_TIMEOUT_EN
    pulse_start();
    base = wr_cnt;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (timeout_err === 1'b1) seen++;
    end
    chk("to_pulse_count", seen, 32'd1);
    chk("to_no_write", wr_cnt - base, 32'd0);
    chk("to_still_busy", {31'd0, busy}, 32'd1);
    send_word(32'hDEADBEEF, 0);
    chk("to_wr", {31'd0, mem_wr}, 32'd1);
    chk("to_wr_addr", mem_addr, 32'd0);
    chk("to_wr_data", mem_data, 32'hDEADBEEF);
    reset = 1'b1; step(); reset = 1'b0;
`else
    seen = 0;
    base = 0;
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
